// File: rtl/handshake_protocol_monitor.sv
// handshake_protocol_monitor: passive N-channel ready/valid checker with sticky errors, first-error capture and transfer counters
module handshake_protocol_monitor #(
    parameter int NUM_CH    = 3,
    parameter int DATA_W    = 4,
    parameter int STALL_MAX = 15,
    parameter int STALL_W   = 4,
    parameter int CNT_W     = 8
) (
    input  logic                     CLK,
    input  logic                     ASYNCRESETN,
    input  logic                     clr,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH-1:0]        ch_ready,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        err_drop,
    output logic [NUM_CH-1:0]        err_data,
    output logic [NUM_CH-1:0]        err_stall,
    output logic                     err_any,
    output logic                     first_err_valid,
    output logic [3:0]               first_err_ch,
    output logic [NUM_CH*CNT_W-1:0]  xfer_cnt
);
    typedef enum logic {IDLE, PENDING} state_t;
    localparam logic [STALL_W-1:0] SMAX = STALL_W'(STALL_MAX);
    logic [NUM_CH-1:0] drop_set, data_set, stall_set, new_set;
    logic [3:0] low_idx;
    for (genvar g = 0; g < NUM_CH; g++) begin : ch
        state_t st_q, st_d;
        logic [DATA_W-1:0] snap_q, snap_d, d;
        logic [STALL_W-1:0] stall_q, stall_d, stall_inc;
        logic [CNT_W-1:0] cnt_q;
        logic v, r, chg, sat, drop_l, data_l, stall_l, xfer_l, drop_q, data_q, stall_err_q;
        assign v = ch_valid[g];
        assign r = ch_ready[g];
        assign d = ch_data[g*DATA_W +: DATA_W];
        assign chg = d != snap_q;
        assign sat = stall_q == '1;
        assign stall_inc = sat ? stall_q : stall_q + 1'b1;
        always_comb begin
            st_d = st_q;
            snap_d = snap_q;
            stall_d = stall_q;
            drop_l = 1'b0;
            data_l = 1'b0;
            stall_l = 1'b0;
            xfer_l = 1'b0;
            if (st_q == IDLE) begin
                if (v && r) begin
                    xfer_l = 1'b1;
                end else if (v) begin
                    st_d = PENDING;
                    snap_d = d;
                    stall_d = STALL_W'(1);
                    stall_l = SMAX == STALL_W'(1);
                end
            end else if (!v) begin
                drop_l = 1'b1;
                st_d = IDLE;
                stall_d = '0;
            end else if (r) begin
                xfer_l = 1'b1;
                data_l = chg;
                st_d = IDLE;
                stall_d = '0;
            end else begin
                data_l = chg;
                snap_d = d;
                stall_d = stall_inc;
                stall_l = !sat && stall_inc == SMAX;
            end
        end
        always_ff @(posedge CLK or negedge ASYNCRESETN) begin
            if (!ASYNCRESETN || clr) begin
                st_q <= IDLE;
                snap_q <= '0;
                stall_q <= '0;
                cnt_q <= '0;
                drop_q <= 1'b0;
                data_q <= 1'b0;
                stall_err_q <= 1'b0;
            end else begin
                st_q <= st_d;
                snap_q <= snap_d;
                stall_q <= stall_d;
                cnt_q <= (xfer_l && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
                drop_q <= drop_q | drop_l;
                data_q <= data_q | data_l;
                stall_err_q <= stall_err_q | stall_l;
            end
        end
        assign drop_set[g] = drop_l;
        assign data_set[g] = data_l;
        assign stall_set[g] = stall_l;
        assign err_drop[g] = drop_q;
        assign err_data[g] = data_q;
        assign err_stall[g] = stall_err_q;
        assign xfer_cnt[g*CNT_W +: CNT_W] = cnt_q;
    end
    assign new_set = drop_set | data_set | stall_set;
    assign err_any = |{err_drop, err_data, err_stall};
    always_comb begin
        low_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (new_set[i]) low_idx = 4'(i);
    end
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN || clr) begin
            first_err_valid <= 1'b0;
            first_err_ch <= '0;
        end else if (!first_err_valid && |new_set) begin
            first_err_valid <= 1'b1;
            first_err_ch <= low_idx;
        end
    end
endmodule

// File: tb/tb_handshake_protocol_monitor.sv
// tb_handshake_protocol_monitor: directed and random traffic against two monitor configurations, checked by a behavioural model
module tb_handshake_protocol_monitor;
    logic CLK = 1'b0;
    logic ASYNCRESETN = 1'b0;
    logic clr = 1'b0;
    logic [2:0] ch_valid = '0;
    logic [2:0] ch_ready = '0;
    logic [11:0] ch_data = '0;
    logic [2:0] o_drop [2];
    logic [2:0] o_data [2];
    logic [2:0] o_stall [2];
    logic o_any [2];
    logic o_fv [2];
    logic [3:0] o_fch [2];
    logic [23:0] a_cnt;
    logic [5:0] b_cnt;
    int passed = 0;
    int total = 0;

    handshake_protocol_monitor dut_a (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .clr(clr),
        .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_data(ch_data),
        .err_drop(o_drop[0]), .err_data(o_data[0]), .err_stall(o_stall[0]),
        .err_any(o_any[0]), .first_err_valid(o_fv[0]), .first_err_ch(o_fch[0]),
        .xfer_cnt(a_cnt)
    );

    handshake_protocol_monitor #(.STALL_MAX(1), .CNT_W(2)) dut_b (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .clr(clr),
        .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_data(ch_data),
        .err_drop(o_drop[1]), .err_data(o_data[1]), .err_stall(o_stall[1]),
        .err_any(o_any[1]), .first_err_valid(o_fv[1]), .first_err_ch(o_fch[1]),
        .xfer_cnt(b_cnt)
    );

    always #5 CLK = ~CLK;

    // Model: an in-flight offer per channel, its latest payload and how long it has waited
    bit mpend [2][3];
    logic [3:0] msnap [2][3];
    int mlen [2][3];
    int mcnt [2][3];
    bit [2:0] md [2];
    bit [2:0] mdt [2];
    bit [2:0] ms [2];
    bit mfv [2];
    int mfch [2];
    int smax [2] = '{15, 1};
    int cmax [2] = '{255, 3};

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 3; c++) begin
                mpend[k][c] = 0;
                msnap[k][c] = '0;
                mlen[k][c] = 0;
                mcnt[k][c] = 0;
            end
            md[k] = '0;
            mdt[k] = '0;
            ms[k] = '0;
            mfv[k] = 0;
            mfch[k] = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit [2:0] nb;
            nb = '0;
            for (int c = 0; c < 3; c++) begin
                logic [3:0] d;
                d = ch_data[c*4 +: 4];
                if (!mpend[k][c]) begin
                    if (ch_valid[c] && ch_ready[c]) mcnt[k][c]++;
                    else if (ch_valid[c]) begin
                        mpend[k][c] = 1;
                        msnap[k][c] = d;
                        mlen[k][c] = 1;
                        if (mlen[k][c] == smax[k]) begin ms[k][c] = 1; nb[c] = 1; end
                    end
                end else if (!ch_valid[c]) begin
                    md[k][c] = 1; nb[c] = 1;
                    mpend[k][c] = 0;
                end else begin
                    if (d != msnap[k][c]) begin mdt[k][c] = 1; nb[c] = 1; end
                    if (ch_ready[c]) begin
                        mcnt[k][c]++;
                        mpend[k][c] = 0;
                    end else begin
                        msnap[k][c] = d;
                        mlen[k][c]++;
                        if (mlen[k][c] == smax[k]) begin ms[k][c] = 1; nb[c] = 1; end
                    end
                end
            end
            if (!mfv[k] && nb != 0) begin
                mfv[k] = 1;
                mfch[k] = nb[0] ? 0 : nb[1] ? 1 : 2;
            end
        end
    endtask

    always @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN || clr) model_clear();
        else model_step();
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    function automatic logic [31:0] cnt_of(input int k, input int c);
        return k == 0 ? 32'(a_cnt[c*8 +: 8]) : 32'(b_cnt[c*2 +: 2]);
    endfunction

    always @(negedge CLK) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("m%0d.err_drop", k), 32'(o_drop[k]), 32'(md[k]));
            chk($sformatf("m%0d.err_data", k), 32'(o_data[k]), 32'(mdt[k]));
            chk($sformatf("m%0d.err_stall", k), 32'(o_stall[k]), 32'(ms[k]));
            chk($sformatf("m%0d.err_any", k), 32'(o_any[k]), 32'(md[k] != 0 || mdt[k] != 0 || ms[k] != 0));
            chk($sformatf("m%0d.first_err_valid", k), 32'(o_fv[k]), 32'(mfv[k]));
            chk($sformatf("m%0d.first_err_ch", k), 32'(o_fch[k]), 32'(mfch[k]));
            for (int c = 0; c < 3; c++)
                chk($sformatf("m%0d.xfer_cnt%0d", k, c), cnt_of(k, c),
                    32'(mcnt[k][c] > cmax[k] ? cmax[k] : mcnt[k][c]));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            @(negedge CLK);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [2:0] r);
        ch_valid = v;
        ch_ready = r;
    endtask

    task automatic pulse_clr();
        drive(3'b000, 3'b000);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
    endtask

    initial begin
        bit [2:0] rv;
        model_clear();
        cyc(2);
        ASYNCRESETN = 1'b1;
        chk("reset err_any", 32'(o_any[0]), 0);
        chk("reset xfer_cnt", 32'(a_cnt), 0);
        // clean traffic and counter saturation
        drive(3'b001, 3'b001);
        cyc(5);
        ch_data[8 +: 4] = 4'hA;
        drive(3'b100, 3'b000);
        cyc(3);
        drive(3'b100, 3'b100);
        cyc(1);
        drive(3'b010, 3'b010);
        cyc(6);
        drive(3'b000, 3'b000);
        cyc(1);
        chk("clean cnt0", 32'(a_cnt[7:0]), 5);
        chk("clean cnt2", 32'(a_cnt[23:16]), 1);
        chk("clean cnt1", 32'(a_cnt[15:8]), 6);
        chk("clean err_any", 32'(o_any[0]), 0);
        chk("sat cnt1", 32'(b_cnt[3:2]), 3);
        chk("sat cnt0", 32'(b_cnt[1:0]), 3);
        // drop, then a later error does not move first_err_ch
        pulse_clr();
        drive(3'b010, 3'b000);
        cyc(2);
        drive(3'b000, 3'b000);
        cyc(1);
        chk("drop err_drop", 32'(o_drop[0]), 32'b010);
        chk("drop first_ch", 32'(o_fch[0]), 1);
        chk("drop err_any", 32'(o_any[0]), 1);
        drive(3'b001, 3'b000);
        cyc(1);
        drive(3'b000, 3'b000);
        cyc(1);
        chk("drop2 err_drop", 32'(o_drop[0]), 32'b011);
        chk("drop2 first_ch", 32'(o_fch[0]), 1);
        // data change mid-stall
        pulse_clr();
        ch_data[3:0] = 4'h3;
        drive(3'b001, 3'b000);
        cyc(1);
        ch_data[3:0] = 4'h5;
        cyc(1);
        drive(3'b001, 3'b001);
        cyc(1);
        drive(3'b000, 3'b000);
        cyc(1);
        chk("data err_data", 32'(o_data[0]), 32'b001);
        chk("data cnt0", 32'(a_cnt[7:0]), 1);
        chk("data err_drop", 32'(o_drop[0]), 0);
        // stall timeout at 15
        pulse_clr();
        ch_data[8 +: 4] = 4'h7;
        drive(3'b100, 3'b000);
        cyc(14);
        chk("stall14 err_stall", 32'(o_stall[0]), 0);
        cyc(1);
        chk("stall15 err_stall", 32'(o_stall[0]), 32'b100);
        chk("stall15 first_ch", 32'(o_fch[0]), 2);
        cyc(20);
        chk("stall35 err_stall", 32'(o_stall[0]), 32'b100);
        chk("stall35 others", 32'({o_drop[0], o_data[0]}), 0);
        drive(3'b100, 3'b100);
        cyc(1);
        pulse_clr();
        drive(3'b101, 3'b000);
        cyc(1);
        drive(3'b000, 3'b000);
        cyc(1);
        chk("simul err_drop", 32'(o_drop[0]), 32'b101);
        chk("simul first_ch", 32'(o_fch[0]), 0);
        // async reset mid-stall, stall continues as a fresh episode
        drive(3'b010, 3'b000);
        cyc(2);
        @(posedge CLK);
        #2 ASYNCRESETN = 1'b0;
        #1;
        chk("async err_any", 32'(o_any[0]), 0);
        chk("async first_valid", 32'(o_fv[0]), 0);
        chk("async err_drop", 32'(o_drop[0]), 0);
        @(negedge CLK);
        ASYNCRESETN = 1'b1;
        cyc(3);
        drive(3'b000, 3'b000);
        cyc(1);
        chk("post-reset drop", 32'(o_drop[0]), 32'b010);
        // clr wins over a same-cycle drop
        drive(3'b001, 3'b000);
        cyc(1);
        clr = 1'b1;
        drive(3'b000, 3'b000);
        cyc(1);
        clr = 1'b0;
        chk("clr err_any", 32'(o_any[0]), 0);
        chk("clr err_drop", 32'(o_drop[0]), 0);
        cyc(1);
        chk("clr drop ignored", 32'(o_drop[0]), 0);
        // randomized traffic
        rv = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 3; c++) begin
                if ($urandom_range(7) == 0) rv[c] = ~rv[c];
                ch_ready[c] = ((i % 500) < 40) ? 1'b0 : ($urandom_range(3) == 0);
                if ($urandom_range(9) == 0) ch_data[c*4 +: 4] = 4'($urandom_range(15));
            end
            ch_valid = rv;
            clr = $urandom_range(299) == 0;
            cyc(1);
        end
        clr = 1'b0;
        cyc(1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
